// File: rtl/bus_mux_reg.sv
// Registered source-select bus: one-stage mux of NUM_SRC sources, one-hot write strobes, sticky select error.
// Optional even-parity output guarded by the BUS_PARITY_EN macro.
module bus_mux_reg #(
  parameter int DATA_W    = 16,
  parameter int NUM_SRC   = 16,
  parameter int NUM_DST   = 16,
  parameter int SEL_W     = 5,
  parameter int HOLD_IDLE = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [SEL_W-1:0]          read,
  input  logic [SEL_W-1:0]          write,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      clr_err,
  output logic [DATA_W-1:0]         busout,
  output logic                      bus_valid,
  output logic [NUM_DST-1:0]        wr_en,
  output logic                      sel_err
`ifdef BUS_PARITY_EN
  ,
  output logic                      bus_parity
`endif
);

  localparam logic [SEL_W-1:0] SRC_MAX = SEL_W'(NUM_SRC);
  localparam logic [SEL_W-1:0] DST_MAX = SEL_W'(NUM_DST);
  localparam logic [SEL_W-1:0] CODE_ZERO = {SEL_W{1'b0}};

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  logic              rd_legal_s;
  logic              rd_idle_s;
  logic              rd_illegal_s;
  logic              wr_illegal_s;
  logic [DATA_W-1:0] slot_s;
  logic [DATA_W-1:0] bus_next_s;
  logic [NUM_DST-1:0] wr_next_s;
  logic              err_next_s;

  // Classify the read and write codes.
  always_comb begin
    rd_idle_s    = (read == CODE_ZERO);
    rd_legal_s   = (read != CODE_ZERO) && (read <= SRC_MAX);
    rd_illegal_s = (read > SRC_MAX);
    wr_illegal_s = (write > DST_MAX);
  end

  // Pick the addressed source slot; code k selects slot k-1.
  always_comb begin
    slot_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (read == SEL_W'(i + 1)) begin
        slot_s = src_data[i*DATA_W +: DATA_W];
      end else begin
        slot_s = slot_s;
      end
    end
  end

  // Next bus value: idle either zeroes or holds, illegal always zeroes.
  always_comb begin
    bus_next_s = {DATA_W{1'b0}};
    if (rd_legal_s) begin
      bus_next_s = slot_s;
    end else if (rd_idle_s && (HOLD_IDLE != 0)) begin
      bus_next_s = busout;
    end else begin
      bus_next_s = {DATA_W{1'b0}};
    end
  end

  // One-hot destination decode; out-of-range codes match no bit.
  always_comb begin
    wr_next_s = {NUM_DST{1'b0}};
    for (int j = 0; j < NUM_DST; j++) begin
      wr_next_s[j] = (write == SEL_W'(j + 1));
    end
  end

  // Sticky error: a new illegal code beats a simultaneous clear.
  always_comb begin
    err_next_s = sel_err;
    if (rd_illegal_s || wr_illegal_s) begin
      err_next_s = 1'b1;
    end else if (clr_err) begin
      err_next_s = 1'b0;
    end else begin
      err_next_s = sel_err;
    end
  end

  // Output pipeline registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busout    <= {DATA_W{1'b0}};
      bus_valid <= 1'b0;
      wr_en     <= {NUM_DST{1'b0}};
      sel_err   <= 1'b0;
    end else begin
      busout    <= bus_next_s;
      bus_valid <= rd_legal_s;
      wr_en     <= wr_next_s;
      sel_err   <= err_next_s;
    end
  end

`ifdef BUS_PARITY_EN
  // Parity tracks the bus register, so a held value keeps its parity.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_parity <= 1'b0;
    end else begin
      bus_parity <= even_parity(bus_next_s);
    end
  end
`endif

endmodule

// File: tb/tb_bus_mux_reg.sv
// Self-checking bench for bus_mux_reg: directed plan steps, then randomized traffic against a spec-level model.
module tb_bus_mux_reg;

  localparam int DATA_W  = 16;
  localparam int NUM_SRC = 16;
  localparam int NUM_DST = 16;
  localparam int SEL_W   = 5;

  logic                      clock;
  logic                      reset;
  logic [SEL_W-1:0]          read;
  logic [SEL_W-1:0]          write;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic                      clr_err;
  logic [DATA_W-1:0]         busout0, busout1;
  logic                      valid0, valid1;
  logic [NUM_DST-1:0]        wr_en0, wr_en1;
  logic                      err0, err1;
`ifdef BUS_PARITY_EN
  logic                      par0, par1;
`endif

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] slots [NUM_SRC];
  int exp_bus [2];
  int exp_valid;
  int exp_wr;
  int exp_err;

  bus_mux_reg #(.HOLD_IDLE(0)) dut0 (
    .clock(clock), .reset(reset), .read(read), .write(write), .src_data(src_data),
    .clr_err(clr_err), .busout(busout0), .bus_valid(valid0), .wr_en(wr_en0), .sel_err(err0)
`ifdef BUS_PARITY_EN
    , .bus_parity(par0)
`endif
  );

  bus_mux_reg #(.HOLD_IDLE(1)) dut1 (
    .clock(clock), .reset(reset), .read(read), .write(write), .src_data(src_data),
    .clr_err(clr_err), .busout(busout1), .bus_valid(valid1), .wr_en(wr_en1), .sel_err(err1)
`ifdef BUS_PARITY_EN
    , .bus_parity(par1)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack_slots();
    for (int i = 0; i < NUM_SRC; i++) src_data[i*DATA_W +: DATA_W] = slots[i];
  endtask

  task automatic model_reset();
    exp_bus[0] = 0; exp_bus[1] = 0;
    exp_valid = 0; exp_wr = 0; exp_err = 0;
  endtask

  // Expected register contents after an edge that sampled rd/wr/clr.
  task automatic model_step(input int rd, input int wr, input int clr);
    bit ok;
    ok = (rd >= 1) && (rd <= NUM_SRC);
    for (int h = 0; h < 2; h++) begin
      if (ok) exp_bus[h] = int'(slots[rd-1]);
      else if (rd == 0 && h == 1) exp_bus[h] = exp_bus[h];
      else exp_bus[h] = 0;
    end
    exp_valid = ok ? 1 : 0;
    exp_wr    = (wr >= 1 && wr <= NUM_DST) ? (1 << (wr - 1)) : 0;
    if (rd > NUM_SRC || wr > NUM_DST) exp_err = 1;
    else if (clr != 0) exp_err = 0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".bus0"},   32'(busout0), 32'(exp_bus[0]));
    check({tag, ".bus1"},   32'(busout1), 32'(exp_bus[1]));
    check({tag, ".valid0"}, 32'(valid0),  32'(exp_valid));
    check({tag, ".valid1"}, 32'(valid1),  32'(exp_valid));
    check({tag, ".wr0"},    32'(wr_en0),  32'(exp_wr));
    check({tag, ".wr1"},    32'(wr_en1),  32'(exp_wr));
    check({tag, ".err0"},   32'(err0),    32'(exp_err));
    check({tag, ".err1"},   32'(err1),    32'(exp_err));
`ifdef BUS_PARITY_EN
    check({tag, ".par0"},   32'(par0),    32'($countones(32'(exp_bus[0])) % 2));
    check({tag, ".par1"},   32'(par1),    32'($countones(32'(exp_bus[1])) % 2));
`endif
  endtask

  // Drive inputs, take one edge, then advance the model and compare.
  task automatic step(input string tag, input int rd, input int wr, input int clr);
    read = SEL_W'(rd); write = SEL_W'(wr); clr_err = clr[0];
    pack_slots();
    @(posedge clock);
    #1;
    model_step(rd, wr, clr);
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1; read = '0; write = '0; clr_err = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) slots[i] = DATA_W'(16'h1000 + i);
    pack_slots();
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all("reset");
    @(negedge clock);
    reset = 1'b0;

    slots[0] = 16'h00AB;
    step("rd1", 1, 0, 0);
    check("rd1.bus_const", 32'(busout0), 32'h00AB);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("midrst.bus", 32'(busout0), 32'h0);
    check("midrst.valid", 32'(valid0), 32'h0);
    check_all("midrst");
    #1 reset = 1'b0;

    slots[15] = 16'hBEEF;
    step("rd16wr3", 16, 3, 0);
    check("rd16.bus_const", 32'(busout0), 32'hBEEF);
    check("wr3.const", 32'(wr_en0), 32'h0004);

    slots[4] = 16'h1234;
    step("rd5", 5, 0, 0);
    step("idle", 0, 0, 0);
    check("idle.zero", 32'(busout0), 32'h0000);
    check("idle.hold", 32'(busout1), 32'h1234);
    step("idle_wr", 0, 7, 0);
    check("idle_wr.hold", 32'(busout1), 32'h1234);

    step("rd17", 17, 0, 0);
    check("rd17.err_const", 32'(err0), 32'h1);
    check("rd17.bus1_zero", 32'(busout1), 32'h0);
    for (int i = 0; i < 3; i++) step("stick", 0, 0, 0);
    step("clr", 0, 0, 1);
    check("clr.const", 32'(err0), 32'h0);

    step("wr20clr", 0, 20, 1);
    check("wr20.err_const", 32'(err0), 32'h1);
    check("wr20.wr_const", 32'(wr_en0), 32'h0);
    step("clr2", 0, 0, 1);

    slots[2] = 16'h0007;
    step("par7", 3, 0, 0);
    slots[3] = 16'h0003;
    step("par3", 4, 0, 0);

    for (int n = 0; n < 300; n++) begin
      int rd, wr, clr;
      for (int i = 0; i < NUM_SRC; i++) slots[i] = DATA_W'($urandom);
      rd  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      wr  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      clr = ($urandom_range(0, 3) == 0) ? 1 : 0;
      step("rand", rd, wr, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised, registered successor to the datapath's combinational source-select bus for the matrix-multiply processor.
- Selects one of NUM_SRC source registers onto a shared DATA_W bus with one-cycle registered latency.
- Decodes a write-select code into one-hot destination load strobes, time-aligned with the bus data.
- Flags illegal select codes through a sticky error bit.

Parameters:
DATA_W, 16, bus width; callers zero-extend narrower sources into their DATA_W slot
NUM_SRC, 16, number of readable sources (read codes 1..NUM_SRC)
NUM_DST, 16, number of writable destinations (write codes 1..NUM_DST)
SEL_W, 5, width of read/write select codes; must satisfy 2**SEL_W > max(NUM_SRC, NUM_DST)
HOLD_IDLE, 0, 0: bus drives zero when idle; 1: bus holds last valid value when idle

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
read  input  SEL_W  source select code; 0 = idle
write  input  SEL_W  destination select code; 0 = none
src_data  input  NUM_SRC*DATA_W  packed sources; slot i occupies bits [i*DATA_W +: DATA_W]
clr_err  input  1  clears sel_err
busout  output  DATA_W  registered bus value
bus_valid  output  1  busout holds data from a legal read this cycle
wr_en  output  NUM_DST  registered one-hot destination strobes
sel_err  output  1  sticky illegal-select flag

Behaviour:
- Reset (async, active-high): busout=0, bus_valid=0, wr_en=0, sel_err=0. Asserting reset mid-transfer discards the captured data immediately; the first legal read after reset release appears one edge later.
- Latency: read/write/src_data are sampled on the rising edge. Results appear on busout/wr_en after that edge and remain stable for the full cycle.
- Read decode, code k sampled:
  - k in 1..NUM_SRC: busout <= slot k-1; bus_valid <= 1. Code 1 maps to slot 0, preserving the existing bus code numbering.
  - k = 0: bus_valid <= 0; busout <= 0 if HOLD_IDLE=0, else busout holds its value.
  - k > NUM_SRC: busout <= 0 regardless of HOLD_IDLE; bus_valid <= 0; sel_err <= 1.
- Write decode, code w sampled:
  - w in 1..NUM_DST: wr_en <= one-hot bit w-1.
  - w = 0: wr_en <= 0.
  - w > NUM_DST: wr_en <= 0; sel_err <= 1.
- wr_en is asserted in the same cycle that busout carries the data, so a destination loads busout on the next edge when its wr_en bit is high.
- A write code may be issued in the same cycle as any read code. Write with read=0 is legal: it writes 0, or the held value when HOLD_IDLE=1.
- wr_en is never more than one-hot.
- sel_err: set on any illegal read or write code. Cleared by clr_err. If clr_err coincides with a new illegal code, the set wins and sel_err stays 1.
- No internal state beyond the busout/bus_valid/wr_en/sel_err registers. There is no FSM; the block is a pure one-stage pipeline.

Optional Feature:
- Macro BUS_PARITY_EN.
- Defined: adds output bus_parity (1 bit), registered alongside busout, equal to XOR of all busout bits (even parity), reset 0. A held value (HOLD_IDLE=1) keeps its parity.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then read=1, src slot0=0x00AB, write=0 -> after one edge busout=0x00AB, bus_valid=1, wr_en=0; assert reset mid-cycle -> busout=0, bus_valid=0 immediately.
- read=16 with slot15=0xBEEF, write=3 -> next cycle busout=0xBEEF, wr_en=0x0004, sel_err=0.
- HOLD_IDLE=0: read=5 (slot4=0x1234) then read=0 -> busout 0x1234 then 0x0000, bus_valid 1 then 0. Repeat with HOLD_IDLE=1 -> busout stays 0x1234, bus_valid=0.
- read=17 (NUM_SRC=16) -> busout=0, bus_valid=0, sel_err=1. sel_err stays 1 over 3 idle cycles. clr_err=1 -> sel_err=0 next cycle.
- write=20 with clr_err=1 in the same cycle -> wr_en=0, sel_err=1 (set wins).
- BUS_PARITY_EN defined: read selecting 0x0007 -> bus_parity=1; read selecting 0x0003 -> bus_parity=0.
